// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit for the 9-bit, 8-register processor: fetches an
// instruction into IR on Run, then sequences the datapath over 1-3 cycles.
module proc_control_fsm #(
   parameter int DATA_W   = 9,
   parameter int REG_BITS = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic [DATA_W-1:0]   DIN,
   output logic                IRin,
   output logic [REG_BITS-1:0] Rin_sel,
   output logic                Rin_en,
   output logic [REG_BITS-1:0] Rout_sel,
   output logic                Rout_en,
   output logic                DINout,
   output logic                Gout,
   output logic                Ain,
   output logic                Gin,
   output logic                AddSub,
   output logic                Done,
   output logic [DATA_W-1:0]   IR,
   output logic [1:0]          fsm_state
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   state_t              state;
   logic [DATA_W-1:0]   ir_q;
   logic [2:0]          opcode;
   logic [REG_BITS-1:0] rx;
   logic [REG_BITS-1:0] ry;
   logic                is_arith;
   logic                fetch;

   assign opcode   = ir_q[DATA_W-1 -: 3];
   assign rx       = ir_q[2*REG_BITS-1 -: REG_BITS];
   assign ry       = ir_q[REG_BITS-1:0];
   assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
   assign fetch    = (state == T0) && Run;

   // Run is only looked at in T0; later states always run to completion.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= T0;
         ir_q  <= '0;
      end else begin
         case (state)
            T0: begin
               if (fetch) begin
                  ir_q  <= DIN;
                  state <= T1;
               end
            end
            T1:      state <= is_arith ? T2 : T0;
            T2:      state <= T3;
            T3:      state <= T0;
            default: state <= T0;
         endcase
      end
   end

   // Combinational decode; everything is held at 0 while Reset is high.
   always_comb begin
      IRin     = 1'b0;
      Rin_sel  = '0;
      Rin_en   = 1'b0;
      Rout_sel = '0;
      Rout_en  = 1'b0;
      DINout   = 1'b0;
      Gout     = 1'b0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      AddSub   = 1'b0;
      Done     = 1'b0;
      if (!Reset) begin
         case (state)
            T0: IRin = Run;
            T1: begin
               case (opcode)
                  OP_MV: begin
                     Rout_sel = ry;
                     Rout_en  = 1'b1;
                     Rin_sel  = rx;
                     Rin_en   = 1'b1;
                     Done     = 1'b1;
                  end
                  OP_MVI: begin
                     DINout  = 1'b1;
                     Rin_sel = rx;
                     Rin_en  = 1'b1;
                     Done    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     Rout_sel = rx;
                     Rout_en  = 1'b1;
                     Ain      = 1'b1;
                  end
                  default: Done = 1'b1;
               endcase
            end
            T2: begin
               // A already holds Rx, so Rx == Ry is safe here.
               Rout_sel = ry;
               Rout_en  = 1'b1;
               Gin      = 1'b1;
               AddSub   = opcode[0];
            end
            T3: begin
               Gout    = 1'b1;
               Rin_sel = rx;
               Rin_en  = 1'b1;
               Done    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign IR        = ir_q;
   assign fsm_state = state;

   bus_one_driver: assert property (@(posedge Clock) disable iff (Reset)
      $onehot0({Rout_en, DINout, Gout}));

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: per-instruction cycle model plus directed
// literal checks for mv, mvi, add, sub, back-to-back, reset and Run drop.
module tb_proc_control_fsm;

   logic       Clock;
   logic       Reset;
   logic       Run;
   logic [8:0] DIN;
   logic       IRin;
   logic [2:0] Rin_sel;
   logic       Rin_en;
   logic [2:0] Rout_sel;
   logic       Rout_en;
   logic       DINout;
   logic       Gout;
   logic       Ain;
   logic       Gin;
   logic       AddSub;
   logic       Done;
   logic [8:0] IR;
   logic [1:0] fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int fetch_cnt = 0;

   logic [14:0] exp_q[$];
   logic [8:0]  m_ir = '0;

   proc_control_fsm #(.DATA_W(9), .REG_BITS(3)) dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
      .IRin(IRin), .Rin_sel(Rin_sel), .Rin_en(Rin_en),
      .Rout_sel(Rout_sel), .Rout_en(Rout_en), .DINout(DINout),
      .Gout(Gout), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
      .Done(Done), .IR(IR), .fsm_state(fsm_state)
   );

   // clock / reset
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp_v);
      end
   endtask

   // {IRin, Rin_sel, Rin_en, Rout_sel, Rout_en, DINout, Gout, Ain, Gin, AddSub, Done}
   function automatic logic [14:0] pk(input logic irin, input logic [2:0] rin_sel,
                                      input logic rin_en, input logic [2:0] rout_sel,
                                      input logic rout_en, input logic dinout,
                                      input logic gout, input logic ain, input logic gin,
                                      input logic addsub, input logic done);
      return {irin, rin_sel, rin_en, rout_sel, rout_en, dinout, gout, ain, gin, addsub, done};
   endfunction

   // Queue up the output pattern of every cycle an instruction will spend after fetch.
   task automatic push_instr(input logic [8:0] d);
      logic [2:0] op, x, y;
      op = d[8:6];
      x  = d[5:3];
      y  = d[2:0];
      case (op)
         3'b000: exp_q.push_back(pk(0, x, 1, y, 1, 0, 0, 0, 0, 0, 1));
         3'b001: exp_q.push_back(pk(0, x, 1, 0, 0, 1, 0, 0, 0, 0, 1));
         3'b010, 3'b011: begin
            exp_q.push_back(pk(0, 0, 0, x, 1, 0, 0, 1, 0, 0, 0));
            exp_q.push_back(pk(0, 0, 0, y, 1, 0, 0, 0, 1, op[0], 0));
            exp_q.push_back(pk(0, x, 1, 0, 0, 0, 1, 0, 0, 0, 1));
         end
         default: exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      endcase
   endtask

   // scoreboard: compare every cycle against the model
   always @(negedge Clock) begin : compare
      logic [14:0] act;
      logic [14:0] exp_v;
      logic        idle;
      act = {IRin, Rin_sel, Rin_en, Rout_sel, Rout_en, DINout, Gout, Ain, Gin, AddSub, Done};
      if (Reset) begin
         exp_q.delete();
         m_ir = '0;
         chk("reset_outputs", 32'(act), 32'd0);
         chk("reset_ir", 32'(IR), 32'd0);
      end else begin
         idle = (exp_q.size() == 0);
         if (idle) exp_v = pk(Run, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else      exp_v = exp_q.pop_front();
         chk("cycle_outputs", 32'(act), 32'(exp_v));
         chk("cycle_ir", 32'(IR), 32'(m_ir));
         chk("bus_exclusive", 32'($countones({Rout_en, DINout, Gout}) > 1), 32'd0);
         if (Done) done_cnt++;
         if (idle && Run) begin
            fetch_cnt++;
            m_ir = DIN;
            push_instr(DIN);
         end
      end
   end

   // driver tasks
   task automatic drive(input logic run, input logic [8:0] din);
      @(posedge Clock);
      #1;
      Run = run;
      DIN = din;
   endtask

   task automatic arith_case(input logic [8:0] instr, input logic sub);
      drive(1'b1, instr);
      drive(1'b0, 9'h000);
      @(negedge Clock);
      chk("arith_t1_rout_sel", 32'(Rout_sel), 32'd1);
      chk("arith_t1_ain", 32'(Ain), 32'd1);
      @(negedge Clock);
      chk("arith_t2_rout_sel", 32'(Rout_sel), 32'd4);
      chk("arith_t2_gin", 32'(Gin), 32'd1);
      chk("arith_t2_addsub", 32'(AddSub), 32'(sub));
      @(negedge Clock);
      chk("arith_t3_gout", 32'(Gout), 32'd1);
      chk("arith_t3_rin", 32'({Rin_sel, Rin_en}), 32'({3'd1, 1'b1}));
      chk("arith_t3_done", 32'(Done), 32'd1);
   endtask

   logic [8:0] b2b_din[1:8];
   int         done_at[$];
   int         exp_done[3];
   int         d0, f0;

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = '0;
      b2b_din = '{9'b000_111_011, 9'h1FF, 9'b010_010_011, 9'h1FF,
                  9'h1FF, 9'h1FF, 9'b110_000_000, 9'h1FF};
      exp_done = '{2, 6, 8};

      @(negedge Clock);
      chk("por_state", 32'(fsm_state), 32'd0);
      chk("por_ir", 32'(IR), 32'd0);
      @(posedge Clock);
      #1 Reset = 1'b0;

      // mv R2,R5
      drive(1'b1, 9'b000_010_101);
      @(negedge Clock);
      chk("mv_irin", 32'(IRin), 32'd1);
      drive(1'b0, 9'h000);
      chk("mv_ir_load", 32'(IR), 32'o025);
      @(negedge Clock);
      chk("mv_rout", 32'({Rout_sel, Rout_en}), 32'({3'd5, 1'b1}));
      chk("mv_rin", 32'({Rin_sel, Rin_en}), 32'({3'd2, 1'b1}));
      chk("mv_done", 32'(Done), 32'd1);
      @(negedge Clock);
      chk("mv_back_to_t0", 32'(fsm_state), 32'd0);

      // mvi R3,#0A5
      drive(1'b1, 9'b001_011_000);
      drive(1'b0, 9'h0A5);
      @(negedge Clock);
      chk("mvi_dinout", 32'(DINout), 32'd1);
      chk("mvi_rin", 32'({Rin_sel, Rin_en}), 32'({3'd3, 1'b1}));
      chk("mvi_done", 32'(Done), 32'd1);
      chk("mvi_no_other", 32'({Rout_en, Gout, Ain}), 32'd0);

      // add R1,R4 then sub R1,R4
      arith_case(9'b010_001_100, 1'b0);
      arith_case(9'b011_001_100, 1'b1);

      // back-to-back mv, add, NOP with Run held high; cycle 1 is the first fetch cycle
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, b2b_din[i]);
         @(negedge Clock);
         if (Done) done_at.push_back(i);
         if (i == 8) chk("nop_no_enables", 32'({Rin_en, Rout_en, DINout, Gout, Ain, Gin}), 32'd0);
      end
      drive(1'b0, 9'h000);
      chk("b2b_done_count", 32'(done_at.size()), 32'd3);
      for (int k = 0; k < 3; k++)
         chk("b2b_done_cycle", 32'((k < done_at.size()) ? done_at[k] : 0), 32'(exp_done[k]));

      // asynchronous reset in T2 of an add
      drive(1'b1, 9'b010_110_111);
      drive(1'b0, 9'h000);
      @(posedge Clock);
      #1 Reset = 1'b1;
      #1;
      chk("rst_async_state", 32'(fsm_state), 32'd0);
      chk("rst_async_ir", 32'(IR), 32'd0);
      chk("rst_async_outs", 32'({IRin, Rin_sel, Rin_en, Rout_sel, Rout_en, DINout, Gout,
                                  Ain, Gin, AddSub, Done}), 32'd0);
      Run = 1'b1;
      #1;
      chk("rst_irin_forced", 32'(IRin), 32'd0);
      Run = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      chk("post_rst_irin", 32'(IRin), 32'd0);
      @(negedge Clock);
      chk("post_rst_state", 32'(fsm_state), 32'd0);

      // random instruction stream with Run toggling mid-instruction
      d0 = done_cnt;
      f0 = fetch_cnt;
      for (int i = 0; i < 250; i++)
         drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
      drive(1'b0, 9'h000);
      repeat (6) @(negedge Clock);
      chk("stream_done_eq_fetch", 32'(done_cnt - d0), 32'(fetch_cnt - f0));
      chk("stream_all_complete", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
